// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer; walks start/data/parity/stop bits on an
// oversampling edge counter, strobes the checkers and deserializer, flags each frame.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] PRESCALE,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               deser_en,
    output logic               data_valid,
    output logic               PAR_ERROR,
    output logic               STP_ERROR
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t             state_q;
    logic [PRESC_W-1:0] edge_q, p_lat_q, p_lat_d;
    logic [3:0]         bit_q;
    logic               par_err_q, stp_err_q, valid_q, eob;
    // Ratios below 2 cannot form a bit period, so fall back to 8.
    assign p_lat_d = (PRESCALE < PRESC_W'(2)) ? PRESC_W'(8) : PRESCALE;
    assign eob     = edge_q == p_lat_q - PRESC_W'(1);
    assign dat_samp_en = state_q != IDLE;
    assign strt_chk_en = state_q == START;
    assign par_chk_en  = state_q == PARITY;
    assign stp_chk_en  = state_q == STOP;
    assign deser_en    = (state_q == DATA) && eob;
    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign data_valid  = valid_q;
    assign PAR_ERROR   = par_err_q;
    assign STP_ERROR   = stp_err_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            p_lat_q   <= PRESC_W'(8);
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == IDLE) begin
                edge_q <= '0;
                bit_q  <= '0;
                if (!RX_IN) begin
                    state_q   <= START;
                    p_lat_q   <= p_lat_d;
                    par_err_q <= 1'b0;
                    stp_err_q <= 1'b0;
                end
            end else if (eob) begin
                edge_q <= '0;
                bit_q  <= bit_q + 4'd1;
                case (state_q)
                    START: begin
                        state_q <= strt_glitch ? IDLE : DATA;
                        if (strt_glitch) bit_q <= '0;
                    end
                    DATA: if (bit_q == 4'(DATA_WIDTH)) state_q <= PAR_EN ? PARITY : STOP;
                    PARITY: begin
                        par_err_q <= par_err;
                        state_q   <= STOP;
                    end
                    STOP: begin
                        stp_err_q <= stp_err;
                        valid_q   <= !stp_err && !par_err_q;
                        state_q   <= IDLE;
                        bit_q     <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end else begin
                edge_q <= edge_q + PRESC_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames push expected frame summaries into a queue;
// a negedge monitor measures each frame the DUT runs and compares at frame end.
module tb_uart_rx_ctrl;
    logic       CLK = 0, RST = 1, RX_IN = 1, PAR_EN = 0;
    logic [5:0] PRESCALE = 6'd8;
    logic       strt_glitch = 0, par_err = 0, stp_err = 0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
    logic       data_valid, PAR_ERROR, STP_ERROR;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PRESCALE(PRESCALE),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .deser_en(deser_en), .data_valid(data_valid), .PAR_ERROR(PAR_ERROR),
        .STP_ERROR(STP_ERROR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int p, len, nstrt, nde, npar, nstp, maxb;
        int valid, perr, serr;
    } exp_t;
    exp_t q[$];
    int compared = 0, mismatched = 0;

    function automatic void check(string name, int act, int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int outs_or();
        return int'(|{edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                      deser_en, data_valid, PAR_ERROR, STP_ERROR});
    endfunction

    // Full frame: line held low p cycles, data LSB first, optional parity, stop
    // held p+1 cycles so the next call lands exactly on the first IDLE cycle.
    task automatic send(input int p, input bit pen, input logic [7:0] d,
                        input bit sg, input bit pe, input bit se, input int pchg);
        exp_t e;
        int pe_eff;
        pe_eff = (p < 2) ? 8 : p;
        e.p = pe_eff;
        e.nstrt = pe_eff;
        if (sg) begin
            e.len = pe_eff; e.nde = 0; e.npar = 0; e.nstp = 0; e.maxb = 0;
            e.valid = 0; e.perr = 0; e.serr = 0;
        end else begin
            e.len = pe_eff * (10 + int'(pen)); e.nde = 8; e.npar = pen ? pe_eff : 0;
            e.nstp = pe_eff; e.maxb = 9 + int'(pen);
            e.perr = int'(pen && pe); e.serr = int'(se);
            e.valid = int'(!se && !(pen && pe));
        end
        q.push_back(e);
        strt_glitch = sg; par_err = pe; stp_err = se;
        PRESCALE = 6'(p); PAR_EN = pen;
        RX_IN = 0;
        if (sg) begin
            tick(2);
            RX_IN = 1;
            tick(pe_eff - 1);
        end else begin
            tick(pe_eff);
            if (pchg != 0) PRESCALE = 6'(pchg);
            for (int i = 0; i < 8; i++) begin
                RX_IN = d[i];
                tick(pe_eff);
            end
            if (pen) begin
                RX_IN = (^d) ^ pe;
                tick(pe_eff);
            end
            RX_IN = 1;
            tick(pe_eff + 1);
        end
    endtask

    // Monitor: a frame is one contiguous run of dat_samp_en; its end is the
    // first low cycle, which is also when data_valid must pulse.
    logic prev_en = 0;
    int len, nstrt, nde, npar, nstp, maxb, bad_edge;
    always @(negedge CLK) begin
        exp_t e;
        if (dat_samp_en) begin
            if (!prev_en) begin
                len = 0; nstrt = 0; nde = 0; npar = 0; nstp = 0; maxb = 0; bad_edge = 0;
                check("start_flags", int'({PAR_ERROR, STP_ERROR}), 0);
                check("start_cnt", int'({edge_cnt, bit_cnt}), 0);
            end
            len++;
            if (strt_chk_en) nstrt++;
            if (par_chk_en) npar++;
            if (stp_chk_en) nstp++;
            if (deser_en) begin
                nde++;
                if (q.size() > 0 && int'(edge_cnt) != q[0].p - 1) bad_edge++;
            end
            if (int'(bit_cnt) > maxb) maxb = int'(bit_cnt);
        end
        if (prev_en && !dat_samp_en) begin
            if (q.size() == 0) check("sb_unexpected_frame", 1, 0);
            else begin
                e = q.pop_front();
                check("frame_len", len, e.len);
                check("strt_chk_cycles", nstrt, e.nstrt);
                check("deser_pulses", nde, e.nde);
                check("deser_edge_bad", bad_edge, 0);
                check("par_chk_cycles", npar, e.npar);
                check("stp_chk_cycles", nstp, e.nstp);
                check("max_bit_cnt", maxb, e.maxb);
                check("data_valid", int'(data_valid), e.valid);
                check("PAR_ERROR", int'(PAR_ERROR), e.perr);
                check("STP_ERROR", int'(STP_ERROR), e.serr);
            end
        end else if (data_valid) begin
            check("dv_spurious", 1, 0);
        end
        prev_en = dat_samp_en;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        tick(3);
        check("reset_outputs", outs_or(), 0);
        RST = 0;
        tick(3);
        check("idle_outputs", outs_or(), 0);
        send(8, 0, 8'h5A, 0, 0, 0, 0);
        tick(3);
        send(16, 1, 8'hA3, 0, 0, 0, 0);
        tick(2);
        send(8, 1, 8'h3C, 0, 1, 0, 0);
        tick(3);
        check("par_flag_holds", int'(PAR_ERROR), 1);
        send(8, 0, 8'h11, 0, 0, 0, 0);
        tick(2);
        send(8, 0, 8'h00, 1, 0, 0, 0);
        tick(2);
        send(32, 0, 8'h00, 0, 0, 1, 0);
        send(32, 0, 8'hFF, 0, 0, 0, 0);
        tick(2);
        send(0, 0, 8'h96, 0, 0, 0, 0);
        tick(2);
        send(16, 0, 8'h42, 0, 0, 0, 8);
        tick(2);
        // Abort at the start of data bit 4: 8 start cycles + 3 data bits seen.
        e.p = 8; e.len = 32; e.nstrt = 8; e.nde = 3; e.npar = 0; e.nstp = 0; e.maxb = 3;
        e.valid = 0; e.perr = 0; e.serr = 0;
        q.push_back(e);
        PRESCALE = 6'd8; PAR_EN = 0; strt_glitch = 0; par_err = 0; stp_err = 0;
        RX_IN = 0;
        tick(33);
        check("abort_bit_cnt", int'(bit_cnt), 4);
        RST = 1;
        RX_IN = 1;
        #1;
        check("async_reset_outputs", outs_or(), 0);
        @(posedge CLK);
        #1;
        RST = 0;
        tick(3);
        send(8, 1, 8'h81, 0, 0, 0, 0);
        tick(5);
        check("sb_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
